control_sequencer: RTL

- Issuing end of the data_path control interface: accepts 32-bit instruction words over a valid/ready handshake and produces every data_path control input.
- Control inputs driven: register selectors, output source selector, output_enable, alu_opcode, immediates.
- Multi-cycle FSM, one instruction in flight.
- Sits between the instruction source and data_path; its outputs connect port-for-port to data_path.

---
 rtl/control_sequencer_pkg.sv | 54 +++++
 rtl/control_sequencer_instruction_decoder.sv | 47 ++++
 rtl/control_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer:
// instruction classes, source codes, states, field layout.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    CLASS_NOP     = 3'b000,
    CLASS_LOADI   = 3'b001,
    CLASS_LOADI2  = 3'b010,
    CLASS_ALU     = 3'b011,
    CLASS_MOVE    = 3'b100,
    CLASS_UNDEF_5 = 3'b101,
    CLASS_UNDEF_6 = 3'b110,
    CLASS_HALT    = 3'b111
  } instr_class_e;

  typedef enum logic [1:0] {
    SOURCE_ALU         = 2'd0,
    SOURCE_IMMEDIATE_1 = 2'd1,
    SOURCE_IMMEDIATE_2 = 2'd2,
    SOURCE_REGISTER    = 2'd3
  } source_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALTED  = 2'd3
  } state_e;

  localparam int CLASS_MSB  = 31;
  localparam int CLASS_LSB  = 29;
  localparam int OPCODE_MSB = 28;
  localparam int OPCODE_LSB = 27;
  localparam int DEST_MSB   = 26;
  localparam int DEST_LSB   = 25;
  localparam int SRC1_MSB   = 24;
  localparam int SRC1_LSB   = 23;
  localparam int SRC2_MSB   = 22;
  localparam int SRC2_LSB   = 21;

  typedef struct packed {
    instr_class_e cls;
    logic [1:0]   alu_opcode;
    logic [1:0]   dest;
    logic [1:0]   src1;
    logic [1:0]   src2;
    logic [31:0]  immediate;
    source_e      source;
    logic         writes;
    logic         halt;
    logic         illegal;
  } decoded_t;

endpackage

// File: rtl/control_sequencer_instruction_decoder.sv
// Combinational instruction word decoder:
// splits fields, classifies, picks the write source.
module control_sequencer_instruction_decoder
  import control_sequencer_pkg::*;
#(
  parameter int IMMEDIATE_WIDTH = 21
) (
  input  logic [31:0] instruction_word,
  output decoded_t    decoded
);

  // Field extraction and per-class control
  always_comb begin
    decoded            = '0;
    decoded.cls        = instr_class_e'(
      instruction_word[CLASS_MSB:CLASS_LSB]);
    decoded.alu_opcode = instruction_word[OPCODE_MSB:OPCODE_LSB];
    decoded.dest       = instruction_word[DEST_MSB:DEST_LSB];
    decoded.src1       = instruction_word[SRC1_MSB:SRC1_LSB];
    decoded.src2       = instruction_word[SRC2_MSB:SRC2_LSB];
    decoded.immediate  = 32'(instruction_word[IMMEDIATE_WIDTH-1:0]);
    decoded.source     = SOURCE_ALU;
    unique case (decoded.cls)
      CLASS_NOP: ;
      CLASS_LOADI: begin
        decoded.source = SOURCE_IMMEDIATE_1;
        decoded.writes = 1'b1;
      end
      CLASS_LOADI2: begin
        decoded.source = SOURCE_IMMEDIATE_2;
        decoded.writes = 1'b1;
      end
      CLASS_ALU: begin
        decoded.source = SOURCE_ALU;
        decoded.writes = 1'b1;
      end
      CLASS_MOVE: begin
        decoded.source = SOURCE_REGISTER;
        decoded.writes = 1'b1;
      end
      CLASS_HALT:    decoded.halt    = 1'b1;
      CLASS_UNDEF_5: decoded.illegal = 1'b1;
      CLASS_UNDEF_6: decoded.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle sequencer driving data_path controls,
// one instruction in flight (accept, decode, execute).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int IMMEDIATE_WIDTH     = 21,
  parameter int RETIRED_COUNT_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           instruction_valid,
  input  logic [31:0]                    instruction_word,
  output logic                           instruction_ready,
  output logic [1:0]                     input_register_selector_1,
  output logic [1:0]                     input_register_selector_2,
  output logic [1:0]                     output_register_selector,
  output logic [1:0]                     output_source_selector,
  output logic                           output_enable,
  output logic [1:0]                     alu_opcode,
  output logic [31:0]                    immediate_1,
  output logic [31:0]                    immediate_2,
  output logic                           halted,
  output logic                           illegal_instruction,
  output logic [RETIRED_COUNT_WIDTH-1:0] retired_count
);

  localparam logic [RETIRED_COUNT_WIDTH-1:0] COUNT_ONE =
    {{(RETIRED_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e   state_q;
  state_e   state_d;
  decoded_t decoded;
  logic     accept;
  logic     retire;
  logic     writes_q;
  logic     halt_q;
  logic     illegal_q;

  control_sequencer_instruction_decoder #(
    .IMMEDIATE_WIDTH(IMMEDIATE_WIDTH)
  ) u_decoder (
    .instruction_word(instruction_word),
    .decoded         (decoded)
  );

  assign instruction_ready = (state_q == IDLE) && reset_n;

  // Next state, handshake and write strobe
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    retire        = 1'b0;
    output_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instruction_valid && instruction_ready) begin
          accept  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (halt_q) begin
          state_d = HALTED;
        end else if (illegal_q) begin
          state_d = IDLE;
        end else begin
          state_d = EXECUTE;
          retire  = 1'b1;
        end
      end
      EXECUTE: begin
        output_enable = writes_q;
        state_d       = IDLE;
      end
      HALTED: ;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Control registers: loaded at accept so they are
  // already valid in DECODE and held until the next write
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      writes_q                  <= 1'b0;
      halt_q                    <= 1'b0;
      illegal_q                 <= 1'b0;
      input_register_selector_1 <= '0;
      input_register_selector_2 <= '0;
      output_register_selector  <= '0;
      output_source_selector    <= '0;
      alu_opcode                <= '0;
      immediate_1               <= '0;
      immediate_2               <= '0;
      halted                    <= 1'b0;
      illegal_instruction       <= 1'b0;
      retired_count             <= '0;
    end else begin
      if (accept) begin
        writes_q  <= decoded.writes;
        halt_q    <= decoded.halt;
        illegal_q <= decoded.illegal;
        if (decoded.writes) begin
          input_register_selector_1 <= decoded.src1;
          input_register_selector_2 <= decoded.src2;
          output_register_selector  <= decoded.dest;
          output_source_selector    <= decoded.source;
          alu_opcode                <= decoded.alu_opcode;
        end
        if (decoded.cls == CLASS_LOADI)
          immediate_1 <= decoded.immediate;
        if (decoded.cls == CLASS_LOADI2)
          immediate_2 <= decoded.immediate;
        if (decoded.illegal)
          illegal_instruction <= 1'b1;
      end
      if (state_q == DECODE && halt_q)
        halted <= 1'b1;
      if (retire)
        retired_count <= retired_count + COUNT_ONE;
    end
  end

endmodule
